instr_fetch_unit: RTL and testbench



---
 rtl/instr_fetch_if.sv | 36 +++
 rtl/instr_fetch_unit.sv | 108 ++++++++++
 tb/tb_instr_fetch_unit.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_if.sv
// Fetch-unit bus: controller handshake, PC redirect, instruction memory port
// and the decoded instruction fields.
interface instr_fetch_if;
   logic        fetch_req;
   logic        pc_load;
   logic [31:0] pc_next;
   logic        fetch_done;
   logic        busy;
   logic [31:0] mem_addr;
   logic        mem_rd;
   logic [31:0] mem_rdata;
   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic [31:0] ir;
   logic [5:0]  opcode;
   logic [4:0]  rs;
   logic [4:0]  rt;
   logic [4:0]  rd;
   logic [4:0]  shamt;
   logic [5:0]  funct;
   logic [15:0] imm16;
   logic [25:0] target26;

   // System side: controller, datapath redirect and instruction memory
   modport master (
      output fetch_req, pc_load, pc_next, mem_rdata,
      input  fetch_done, busy, mem_addr, mem_rd, pc, pc_plus4, ir,
             opcode, rs, rt, rd, shamt, funct, imm16, target26
   );

   modport slave (
      input  fetch_req, pc_load, pc_next, mem_rdata,
      output fetch_done, busy, mem_addr, mem_rd, pc, pc_plus4, ir,
             opcode, rs, rt, rd, shamt, funct, imm16, target26
   );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns PC and IR, runs a fixed-latency instruction
// memory read and accepts branch/jump redirects from the datapath.
module instr_fetch_unit #(
   parameter int unsigned MEM_LATENCY = 2,
   parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
   input logic          clock,
   input logic          reset,
   instr_fetch_if.slave bus
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

   state_t      state;
   logic [31:0] pc_q;
   logic [31:0] ir_q;
   logic [31:0] mem_addr_q;
   logic [3:0]  wait_cnt;
   logic [31:0] pend_pc;
   logic        pend_valid;
   logic        fetch_done_q;
   logic        mem_rd_q;
   logic        busy_q;

   logic [31:0] redirect_pc;
   logic [31:0] pc_inc;

   assign redirect_pc = {bus.pc_next[31:2], 2'b00};
   assign pc_inc      = pc_q + 32'd4;

   // NOTE: every register here, including the pending redirect, is reset
   // asynchronously so an aborted fetch leaves no trace; sequential state
   // uses non-blocking assignments only.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         pc_q         <= RESET_PC;
         ir_q         <= '0;
         mem_addr_q   <= RESET_PC;
         wait_cnt     <= '0;
         pend_pc      <= '0;
         pend_valid   <= 1'b0;
         fetch_done_q <= 1'b0;
         mem_rd_q     <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         fetch_done_q <= 1'b0;
         mem_rd_q     <= 1'b0;
         case (state)
            IDLE, DONE: begin
               if (bus.pc_load) pc_q <= redirect_pc;
               if (bus.fetch_req) begin
                  state      <= REQ;
                  mem_rd_q   <= 1'b1;
                  busy_q     <= 1'b1;
                  mem_addr_q <= bus.pc_load ? redirect_pc : pc_q;
               end else begin
                  state  <= IDLE;
                  busy_q <= 1'b0;
               end
            end
            REQ: begin
               state    <= WAIT;
               wait_cnt <= 4'(MEM_LATENCY);
               if (bus.pc_load) begin
                  pend_pc    <= redirect_pc;
                  pend_valid <= 1'b1;
               end
            end
            WAIT: begin
               wait_cnt <= wait_cnt - 4'd1;
               if (wait_cnt == 4'd1) begin
                  state        <= DONE;
                  ir_q         <= bus.mem_rdata;
                  fetch_done_q <= 1'b1;
                  busy_q       <= 1'b0;
                  pend_valid   <= 1'b0;
                  // A redirect arriving in the final WAIT cycle is the latest one
                  if (bus.pc_load)     pc_q <= redirect_pc;
                  else if (pend_valid) pc_q <= pend_pc;
                  else                 pc_q <= pc_inc;
               end else if (bus.pc_load) begin
                  pend_pc    <= redirect_pc;
                  pend_valid <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.fetch_done = fetch_done_q;
   assign bus.busy       = busy_q;
   assign bus.mem_rd     = mem_rd_q;
   assign bus.mem_addr   = mem_addr_q;
   assign bus.pc         = pc_q;
   assign bus.pc_plus4   = pc_inc;
   assign bus.ir         = ir_q;
   assign bus.opcode     = ir_q[31:26];
   assign bus.rs         = ir_q[25:21];
   assign bus.rt         = ir_q[20:16];
   assign bus.rd         = ir_q[15:11];
   assign bus.shamt      = ir_q[10:6];
   assign bus.funct      = ir_q[5:0];
   assign bus.imm16      = ir_q[15:0];
   assign bus.target26   = ir_q[25:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: fetch timing, back-to-back fetches,
// PC redirects, PC wrap and reset abort, against a latency-exact memory model.
module tb_instr_fetch_unit;
   localparam int unsigned LAT = 2;

   logic clock;
   logic reset;
   instr_fetch_if ifc ();

   instr_fetch_unit #(.MEM_LATENCY(LAT), .RESET_PC(32'h0000_0000)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (ifc.slave)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int n_pass  = 0;
   int n_total = 0;

   // Memory model: data is valid only in the cycle MEM_LATENCY after the strobe
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      case (a)
         32'h0000_0000: return 32'h012A_4020;
         32'h0000_0004: return 32'h8D09_0004;
         32'h0000_0008: return 32'hAD09_0008;
         default:       return a ^ 32'h5A5A_0000;
      endcase
   endfunction

   int lat_cnt;
   always @(posedge clock or posedge reset) begin
      if (reset)                         lat_cnt <= 0;
      else if (ifc.mem_rd)               lat_cnt <= 1;
      else if (lat_cnt != 0 && lat_cnt < 15) lat_cnt <= lat_cnt + 1;
   end
   assign ifc.mem_rdata = (lat_cnt == int'(LAT)) ? mem_word(ifc.mem_addr) : 32'hDEAD_BEEF;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic wait_done(input int max_cycles, output int n);
      n = 0;
      do begin
         step();
         n++;
      end while (ifc.fetch_done !== 1'b1 && n < max_cycles);
      if (ifc.fetch_done !== 1'b1) begin
         n_total++;
         $display("FAIL wait_done: fetch_done not seen within %0d cycles", max_cycles);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      ifc.fetch_req = 1'b0;
      ifc.pc_load   = 1'b0;
      ifc.pc_next   = '0;
      #12;
      n_total++; if ({ifc.pc, ifc.ir, ifc.mem_addr} !== 96'h0) $display("FAIL reset_regs: pc=%h ir=%h addr=%h want 0", ifc.pc, ifc.ir, ifc.mem_addr); else n_pass++;
      n_total++; if ({ifc.fetch_done, ifc.mem_rd, ifc.busy} !== 3'b000) $display("FAIL reset_ctrl: done/rd/busy=%b want 000", {ifc.fetch_done, ifc.mem_rd, ifc.busy}); else n_pass++;
      @(negedge clock);
      reset = 1'b0;
      step();
      step();
      n_total++; if (ifc.busy !== 1'b0 || ifc.mem_rd !== 1'b0) $display("FAIL idle_stay: busy=%b rd=%b want 0 0", ifc.busy, ifc.mem_rd); else n_pass++;
   endtask

   task automatic test_single_fetch();
      ifc.fetch_req = 1'b1;
      step();                       // cycle 1: REQ
      ifc.fetch_req = 1'b0;
      n_total++; if (ifc.mem_rd !== 1'b1 || ifc.mem_addr !== 32'h0 || ifc.busy !== 1'b1) $display("FAIL req_cycle: rd=%b addr=%h busy=%b want 1 0 1", ifc.mem_rd, ifc.mem_addr, ifc.busy); else n_pass++;
      step();                       // cycle 2: WAIT
      n_total++; if (ifc.mem_rd !== 1'b0 || ifc.busy !== 1'b1 || ifc.fetch_done !== 1'b0) $display("FAIL wait_cycle: rd=%b busy=%b done=%b want 0 1 0", ifc.mem_rd, ifc.busy, ifc.fetch_done); else n_pass++;
      step();                       // cycle 3: last WAIT, pc not yet advanced
      n_total++; if (ifc.fetch_done !== 1'b0 || ifc.pc !== 32'h0 || ifc.ir !== 32'h0) $display("FAIL early_update: done=%b pc=%h ir=%h want 0 0 0", ifc.fetch_done, ifc.pc, ifc.ir); else n_pass++;
      step();                       // cycle 4: DONE
      n_total++; if (ifc.fetch_done !== 1'b1 || ifc.busy !== 1'b0) $display("FAIL done_cycle: done=%b busy=%b want 1 0", ifc.fetch_done, ifc.busy); else n_pass++;
      n_total++; if (ifc.ir !== 32'h012A_4020 || ifc.pc !== 32'h4) $display("FAIL fetch1: ir=%h pc=%h want 012a4020 4", ifc.ir, ifc.pc); else n_pass++;
      n_total++; if (ifc.opcode !== 6'h0 || ifc.funct !== 6'h20 || ifc.rd !== 5'd8 || ifc.rs !== 5'd9 || ifc.rt !== 5'd10 || ifc.target26 !== 26'h12A_4020)
         $display("FAIL decode1: op=%h fn=%h rd=%0d rs=%0d rt=%0d t26=%h want 0 20 8 9 10 12a4020", ifc.opcode, ifc.funct, ifc.rd, ifc.rs, ifc.rt, ifc.target26); else n_pass++;
      step();
      n_total++; if (ifc.fetch_done !== 1'b0 || ifc.busy !== 1'b0 || ifc.ir !== 32'h012A_4020) $display("FAIL done_pulse: done=%b busy=%b ir=%h want 0 0 012a4020", ifc.fetch_done, ifc.busy, ifc.ir); else n_pass++;
   endtask

   task automatic test_back_to_back();
      int n;
      ifc.fetch_req = 1'b1;
      wait_done(10, n);
      n_total++; if (n !== 4 || ifc.ir !== 32'h8D09_0004 || ifc.pc !== 32'h8) $display("FAIL b2b_first: cycles=%0d ir=%h pc=%h want 4 8d090004 8", n, ifc.ir, ifc.pc); else n_pass++;
      wait_done(10, n);
      ifc.fetch_req = 1'b0;
      n_total++; if (n !== 4 || ifc.mem_addr !== 32'h8 || ifc.pc !== 32'hC) $display("FAIL b2b_second: cycles=%0d addr=%h pc=%h want 4 8 c", n, ifc.mem_addr, ifc.pc); else n_pass++;
      n_total++; if (ifc.opcode !== 6'h2B || ifc.imm16 !== 16'h0008) $display("FAIL b2b_decode: op=%h imm=%h want 2b 0008", ifc.opcode, ifc.imm16); else n_pass++;
      step();
      n_total++; if (ifc.busy !== 1'b0 || ifc.mem_rd !== 1'b0) $display("FAIL b2b_stop: busy=%b rd=%b want 0 0", ifc.busy, ifc.mem_rd); else n_pass++;
   endtask

   task automatic test_redirect_idle();
      int n;
      ifc.pc_load   = 1'b1;
      ifc.pc_next   = 32'h0000_0043;
      ifc.fetch_req = 1'b1;
      step();
      ifc.pc_load   = 1'b0;
      ifc.fetch_req = 1'b0;
      n_total++; if (ifc.pc !== 32'h40 || ifc.mem_addr !== 32'h40 || ifc.mem_rd !== 1'b1) $display("FAIL redir_idle: pc=%h addr=%h rd=%b want 40 40 1", ifc.pc, ifc.mem_addr, ifc.mem_rd); else n_pass++;
      wait_done(10, n);
      n_total++; if (n !== 3 || ifc.pc !== 32'h44 || ifc.ir !== 32'h5A5A_0040) $display("FAIL redir_idle_fetch: cycles=%0d pc=%h ir=%h want 3 44 5a5a0040", n, ifc.pc, ifc.ir); else n_pass++;
      step();
   endtask

   task automatic test_redirect_wait();
      int n;
      ifc.fetch_req = 1'b1;
      step();                       // REQ, fetching 0x44
      ifc.fetch_req = 1'b0;
      step();                       // first WAIT
      ifc.pc_load = 1'b1;
      ifc.pc_next = 32'h0000_0100;
      step();                       // last WAIT
      ifc.pc_next = 32'h0000_0200;
      n_total++; if (ifc.pc !== 32'h44 || ifc.mem_addr !== 32'h44) $display("FAIL redir_wait_hold: pc=%h addr=%h want 44 44", ifc.pc, ifc.mem_addr); else n_pass++;
      step();                       // DONE
      ifc.pc_load = 1'b0;
      n_total++; if (ifc.fetch_done !== 1'b1 || ifc.ir !== 32'h5A5A_0044 || ifc.pc !== 32'h200) $display("FAIL redir_wait: done=%b ir=%h pc=%h want 1 5a5a0044 200", ifc.fetch_done, ifc.ir, ifc.pc); else n_pass++;
      step();
      ifc.fetch_req = 1'b1;
      step();
      ifc.fetch_req = 1'b0;
      n_total++; if (ifc.mem_addr !== 32'h200 || ifc.mem_rd !== 1'b1) $display("FAIL redir_next_addr: addr=%h rd=%b want 200 1", ifc.mem_addr, ifc.mem_rd); else n_pass++;
      wait_done(10, n);
      n_total++; if (ifc.pc !== 32'h204 || ifc.ir !== 32'h5A5A_0200) $display("FAIL redir_cleared: pc=%h ir=%h want 204 5a5a0200", ifc.pc, ifc.ir); else n_pass++;
      step();
   endtask

   task automatic test_pc_wrap();
      int n;
      ifc.pc_load = 1'b1;
      ifc.pc_next = 32'hFFFF_FFFC;
      step();
      ifc.pc_load = 1'b0;
      n_total++; if (ifc.pc !== 32'hFFFF_FFFC || ifc.pc_plus4 !== 32'h0 || ifc.busy !== 1'b0) $display("FAIL wrap_pre: pc=%h p4=%h busy=%b want fffffffc 0 0", ifc.pc, ifc.pc_plus4, ifc.busy); else n_pass++;
      ifc.fetch_req = 1'b1;
      step();
      ifc.fetch_req = 1'b0;
      wait_done(10, n);
      n_total++; if (ifc.pc !== 32'h0 || ifc.ir !== 32'hA5A5_FFFC || ifc.pc_plus4 !== 32'h4) $display("FAIL wrap_post: pc=%h ir=%h p4=%h want 0 a5a5fffc 4", ifc.pc, ifc.ir, ifc.pc_plus4); else n_pass++;
      step();
   endtask

   task automatic test_reset_abort();
      int n;
      int seen;
      ifc.pc_load   = 1'b1;
      ifc.pc_next   = 32'h0000_0080;
      ifc.fetch_req = 1'b1;
      step();                       // REQ at 0x80
      ifc.pc_load   = 1'b0;
      ifc.fetch_req = 1'b0;
      step();                       // WAIT 1
      step();                       // WAIT 2
      reset = 1'b1;
      #1;
      n_total++; if (ifc.pc !== 32'h0 || ifc.ir !== 32'h0 || ifc.mem_rd !== 1'b0 || ifc.busy !== 1'b0) $display("FAIL abort: pc=%h ir=%h rd=%b busy=%b want 0 0 0 0", ifc.pc, ifc.ir, ifc.mem_rd, ifc.busy); else n_pass++;
      #2;
      reset = 1'b0;
      seen = 0;
      for (int i = 0; i < 5; i++) begin
         step();
         if (ifc.fetch_done === 1'b1 || ifc.busy === 1'b1) seen++;
      end
      n_total++; if (seen !== 0) $display("FAIL abort_quiet: %0d cycles with done/busy, want 0", seen); else n_pass++;
      ifc.fetch_req = 1'b1;
      wait_done(10, n);
      ifc.fetch_req = 1'b0;
      n_total++; if (n !== 4 || ifc.pc !== 32'h4 || ifc.ir !== 32'h012A_4020) $display("FAIL after_abort: cycles=%0d pc=%h ir=%h want 4 4 012a4020", n, ifc.pc, ifc.ir); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_single_fetch();
      test_back_to_back();
      test_redirect_idle();
      test_redirect_wait();
      test_pc_wrap();
      test_reset_abort();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
